maze_tile_fetch: RTL and testbench
==================================

Name: maze_tile_fetch

Overview:
Upstream feeder for Map_Sprite. Converts the VGA raster position into a maze tile lookup. Holds the 28x31 tile map (5-bit tile code plus 2-bit rotation per cell) and presents GRID_SELECT, ROTATE_SELECT, X_INDEX and Y_INDEX registered to Map_Sprite. Game logic updates tiles (for example, pellet eaten) through a req/ack write port that is serviced only during blanking.

Parameters:
MAP_COLS, 28, tiles per row
MAP_ROWS, 31, tile rows
MAP_X0, 208, screen x of map pixel (0,0), which centres 224 px in 640
MAP_Y0, 116, screen y of map pixel (0,0), which centres 248 px in 480
TILE_BLANK, 0, tile code for free space / outside map

Ports:
CLK  in  1  pixel clock
RST_N  in  1  asynchronous, active-low reset
PIX_X  in  10  current raster x
PIX_Y  in  10  current raster y
PIX_VALID  in  1  active-video qualifier for PIX_X/PIX_Y
WR_REQ  in  1  tile write request; held until WR_ACK
WR_COL  in  5  target column
WR_ROW  in  5  target row
WR_TILE  in  5  tile code to store
WR_ROT  in  2  rotation to store
WR_ACK  out  1  one-cycle acceptance pulse
BUSY  out  1  map clear sweep in progress
GRID_SELECT  out  5  to Map_Sprite
ROTATE_SELECT  out  2  to Map_Sprite
X_INDEX  out  3  to Map_Sprite
Y_INDEX  out  3  to Map_Sprite
TILE_VALID  out  1  outputs correspond to an in-map, active pixel

Behaviour:
- Reset is asynchronous and active-low (RST_N). On assertion all outputs go to 0, except BUSY, which goes to 1. The FSM enters CLEAR and the sweep counter goes to 0. Tile RAM contents are not reset.
- FSM, CLEAR state: each cycle writes {TILE_BLANK, rot 0} to address cnt, then cnt++. After address MAP_COLS*MAP_ROWS-1 (867) it moves to IDLE and BUSY drops on the next edge. BUSY is high for exactly 868 cycles after reset release.
- FSM, IDLE state: no sweep. CLEAR is re-entered only via RST_N.
- Relative coordinates: rx = PIX_X - MAP_X0, ry = PIX_Y - MAP_Y0, 10-bit unsigned.
- In-map test: PIX_X >= MAP_X0, PIX_Y >= MAP_Y0, rx < 8*MAP_COLS and ry < 8*MAP_ROWS.
- Address: col = rx[7:3], row = ry[7:3], addr = row*MAP_COLS + col (10 bits).
- Pipeline: latency exactly 2 cycles from PIX_X/PIX_Y/PIX_VALID to outputs.
  - S0 registers addr, rx[2:0], ry[2:0] and hit = PIX_VALID & in-map & !BUSY.
  - S1 performs the synchronous RAM read; outputs are registered at the end of S1.
- Outputs when hit: GRID_SELECT/ROTATE_SELECT = RAM word, X_INDEX = rx[2:0], Y_INDEX = ry[2:0], TILE_VALID = 1.
- Outputs when not hit: GRID_SELECT = TILE_BLANK, ROTATE_SELECT = 0, X_INDEX = Y_INDEX = 0, TILE_VALID = 0.
- Write handshake: accepted on a cycle where WR_REQ = 1, PIX_VALID = 0, BUSY = 0 and WR_ACK was 0 on the previous cycle.
  - RAM is written that edge and WR_ACK pulses high for 1 cycle.
  - Back-to-back requests are therefore accepted at most every 2 cycles.
- WR_REQ during active video or BUSY is stalled: no ACK, the request is held by the requester, and WR_* must stay stable until ACK.
- Out-of-range write (WR_COL >= MAP_COLS or WR_ROW >= MAP_ROWS): acknowledged normally, RAM unchanged.
- Read and write to the same address cannot coincide, because writes are blanking-only and reads are active-only. The sweep has priority over the write port.
- Reset mid-sweep or mid-handshake: the sweep restarts from 0 and any pending request is dropped (ACK stays 0).

Decomposition:
- Package pacman_map_pkg:
  - MAP_COLS/MAP_ROWS/TILE_W = 8, MAP_DEPTH = 868, MAP_AW = 10
  - tile code localparams (TILE_BLANK, TILE_BOUND_CORNER, TILE_BOUND_WALL, TILE_INT_WALL, TILE_INT_CORNER)
  - rotation codes ROT_0/90/180/270
  - struct tile_entry_t {tile[4:0], rot[1:0]}
- Sub-module maze_tile_ram: 868 x 7 bits, one synchronous read port, one write port, no reset.
- Sweep FSM, pixel pipeline and write arbitration live in maze_tile_fetch.

Test Plan:
- Release RST_N, hold PIX_VALID = 0 -> BUSY = 1 for exactly 868 cycles, then 0. A probe of every cell afterwards returns GRID_SELECT = 0, ROTATE_SELECT = 0.
- After clear, PIX_VALID = 0, write col 3, row 2, tile 4, rot 1 -> WR_ACK one pulse. Then PIX_X = 208+27 = 235, PIX_Y = 116+21 = 137, PIX_VALID = 1 -> two cycles later GRID_SELECT = 4, ROTATE_SELECT = 1, X_INDEX = 3, Y_INDEX = 5, TILE_VALID = 1.
- Pixel outside map: PIX_X = 100 (x left of MAP_X0) and PIX_X = 432 (rx = 224), with PIX_VALID = 1 -> TILE_VALID = 0, GRID_SELECT = 0, X_INDEX = 0 after 2 cycles.
- WR_REQ asserted while PIX_VALID = 1 for 50 cycles -> no ACK. PIX_VALID falls -> ACK on that cycle's edge and data lands.
- Write to col 28 or row 31 -> ACK pulse, and a full readback shows no cell changed.
- Assert RST_N = 0 at sweep count 400 after a prior write of tile 7 to cell 0 -> BUSY stays high, the sweep restarts, a full 868 cycles elapse, and cell 0 reads 0.

Source files
------------

// File: rtl/maze_tile_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pacman_map_pkg
//  Brief    : Shared maze map geometry, tile codes, rotation codes and the
//             tile RAM word layout used by the maze tile fetch block.
//  Revision : 1.0  initial release
// ============================================================================
package pacman_map_pkg;

    localparam int MAP_COLS  = 28;
    localparam int MAP_ROWS  = 31;
    localparam int TILE_W    = 8;
    localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
    localparam int MAP_AW    = 10;

    localparam logic [4:0] TILE_BLANK        = 5'd0;
    localparam logic [4:0] TILE_BOUND_CORNER = 5'd1;
    localparam logic [4:0] TILE_BOUND_WALL   = 5'd2;
    localparam logic [4:0] TILE_INT_WALL     = 5'd3;
    localparam logic [4:0] TILE_INT_CORNER   = 5'd4;

    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

    // Sweep FSM encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    typedef struct packed {
        logic [4:0] tile;
        logic [1:0] rot;
    } tile_entry_t;

    // Row-major linear address of a map cell
    function automatic logic [MAP_AW-1:0] map_addr(input logic [4:0] col,
                                                   input logic [4:0] row);
        return MAP_AW'(row) * MAP_AW'(MAP_COLS) + MAP_AW'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_tile_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : maze_tile_fetch_if
//  Brief    : Raster input, tile write handshake and Map_Sprite output bundle
//             of the maze tile fetch block.
//  Revision : 1.0  initial release
// ============================================================================
interface maze_tile_fetch_if;

    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_valid;
    logic       wr_req;
    logic [4:0] wr_col;
    logic [4:0] wr_row;
    logic [4:0] wr_tile;
    logic [1:0] wr_rot;
    logic       wr_ack;
    logic       busy;
    logic [4:0] grid_select;
    logic [1:0] rotate_select;
    logic [2:0] x_index;
    logic [2:0] y_index;
    logic       tile_valid;

    modport master (
        output pix_x, pix_y, pix_valid,
        output wr_req, wr_col, wr_row, wr_tile, wr_rot,
        input  wr_ack, busy,
        input  grid_select, rotate_select, x_index, y_index, tile_valid
    );

    modport slave (
        input  pix_x, pix_y, pix_valid,
        input  wr_req, wr_col, wr_row, wr_tile, wr_rot,
        output wr_ack, busy,
        output grid_select, rotate_select, x_index, y_index, tile_valid
    );

endinterface
`default_nettype wire

// File: rtl/maze_tile_ram.sv
`default_nettype none
// ============================================================================
//  Module   : maze_tile_ram
//  Brief    : 868 x 7 tile map storage, one write port and one synchronous
//             read port, no reset on contents.
//  Revision : 1.0  initial release
// ============================================================================
module maze_tile_ram
    import pacman_map_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [MAP_AW-1:0] waddr,
    input  tile_entry_t            wdata,
    input  wire logic [MAP_AW-1:0] raddr,
    output tile_entry_t            rdata
);

    tile_entry_t mem [0:MAP_DEPTH-1];

    // Write first-come, registered read; callers never address the same cell
    // with both ports in one cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/maze_tile_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : maze_tile_fetch
//  Brief    : Maps the VGA raster position onto the maze tile map and hands
//             tile code, rotation and in-tile pixel offsets to Map_Sprite two
//             cycles later. Clears the map after reset and accepts game-logic
//             tile writes during blanking.
//  Revision : 1.0  initial release
// ============================================================================
module maze_tile_fetch
    import pacman_map_pkg::*;
#(
    parameter int MAP_X0 = 208,
    parameter int MAP_Y0 = 116
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    maze_tile_fetch_if.slave  bus
);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [MAP_AW-1:0] r_cnt;
    logic              w_busy;

    logic [9:0]        w_rx;
    logic [9:0]        w_ry;
    logic              w_in_map;
    logic              w_hit;

    logic [MAP_AW-1:0] r_addr0;
    logic [2:0]        r_xi0;
    logic [2:0]        r_yi0;
    logic              r_hit0;
    logic [2:0]        r_xi1;
    logic [2:0]        r_yi1;
    logic              r_hit1;

    logic              r_ack;
    logic              w_accept;
    logic              w_wr_in_range;
    logic              w_we;
    logic [MAP_AW-1:0] w_waddr;
    tile_entry_t       w_wdata;
    tile_entry_t       w_rdata;

    // Sweep state and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Leave CLEAR once the last map cell has been written
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_CLEAR) && (r_cnt == MAP_AW'(MAP_DEPTH - 1))) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // BUSY tracks the sweep state directly
    always_comb begin
        w_busy = (r_state == ST_CLEAR);
    end

    // Raster position relative to the map origin and map bounds test
    always_comb begin
        w_rx     = bus.pix_x - 10'(MAP_X0);
        w_ry     = bus.pix_y - 10'(MAP_Y0);
        w_in_map = (bus.pix_x >= 10'(MAP_X0)) && (bus.pix_y >= 10'(MAP_Y0)) &&
                   (w_rx < 10'(TILE_W * MAP_COLS)) && (w_ry < 10'(TILE_W * MAP_ROWS));
        w_hit    = bus.pix_valid && w_in_map && !w_busy;
    end

    // Pixel pipeline: S0 holds address/offsets, S1 aligns them with RAM data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr0 <= '0;
            r_xi0   <= '0;
            r_yi0   <= '0;
            r_hit0  <= 1'b0;
            r_xi1   <= '0;
            r_yi1   <= '0;
            r_hit1  <= 1'b0;
        end else begin
            r_addr0 <= map_addr(w_rx[7:3], w_ry[7:3]);
            r_xi0   <= w_rx[2:0];
            r_yi0   <= w_ry[2:0];
            r_hit0  <= w_hit;
            r_xi1   <= r_hit0 ? r_xi0 : 3'd0;
            r_yi1   <= r_hit0 ? r_yi0 : 3'd0;
            r_hit1  <= r_hit0;
        end
    end

    // Write acceptance: blanking only, not while sweeping, never two in a row
    always_comb begin
        w_accept      = bus.wr_req && !bus.pix_valid && !w_busy && !r_ack;
        w_wr_in_range = (bus.wr_col < 5'(MAP_COLS)) && (bus.wr_row < 5'(MAP_ROWS));
    end

    // Acknowledge pulse, also covers out-of-range writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_accept;
        end
    end

    // RAM write port: the clear sweep owns it while running
    always_comb begin
        w_we    = w_busy || (w_accept && w_wr_in_range);
        w_waddr = w_busy ? r_cnt : map_addr(bus.wr_col, bus.wr_row);
        w_wdata = w_busy ? tile_entry_t'{tile: TILE_BLANK, rot: ROT_0}
                         : tile_entry_t'{tile: bus.wr_tile, rot: bus.wr_rot};
    end

    maze_tile_ram u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (r_addr0),
        .rdata (w_rdata)
    );

    // RAM data is unreset, so it is masked by the registered hit flag
    always_comb begin
        bus.grid_select   = r_hit1 ? w_rdata.tile : TILE_BLANK;
        bus.rotate_select = r_hit1 ? w_rdata.rot  : ROT_0;
        bus.x_index       = r_xi1;
        bus.y_index       = r_yi1;
        bus.tile_valid    = r_hit1;
        bus.wr_ack        = r_ack;
        bus.busy          = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_maze_tile_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maze_tile_fetch
//  Brief    : Self-checking bench for maze_tile_fetch: clear sweep timing,
//             pixel lookup vectors, write handshake stalls and resets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_maze_tile_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    maze_tile_fetch_if bus ();

    maze_tile_fetch #(.MAP_X0(208), .MAP_Y0(116)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] model [0:867];

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        v;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] ex(input logic [4:0] t, input logic [1:0] r,
                                       input logic [2:0] xi, input logic [2:0] yi,
                                       input logic v);
        return {t, r, xi, yi, v};
    endfunction

    function automatic logic [13:0] outs();
        return {bus.grid_select, bus.rotate_select, bus.x_index, bus.y_index, bus.tile_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic probe(input int x, input int y, output logic [13:0] res);
        @(negedge clk);
        bus.pix_x = 10'(x);
        bus.pix_y = 10'(y);
        bus.pix_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        res = outs();
    endtask

    // Full-map readback against the model, one aggregated comparison
    task automatic readback(input string name);
        int errs;
        logic [13:0] r;
        errs = 0;
        for (int row = 0; row < 31; row++) begin
            for (int col = 0; col < 28; col++) begin
                probe(208 + 8 * col + 1, 116 + 8 * row + 2, r);
                if (r !== {model[row * 28 + col], 3'd1, 3'd2, 1'b1}) begin
                    if (errs == 0)
                        $display("FAIL %s cell c%0d r%0d: got %0h want %0h", name, col, row,
                                 r, {model[row * 28 + col], 3'd1, 3'd2, 1'b1});
                    errs++;
                end
            end
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        total++;
        if (errs != 0) bad++;
    endtask

    task automatic write_tile(input int col, input int row, input int tile, input int rot);
        int n;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.wr_col = 5'(col);
        bus.wr_row = 5'(row);
        bus.wr_tile = 5'(tile);
        bus.wr_rot = 2'(rot);
        bus.wr_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.wr_ack && n < 10);
        check("wr_ack_seen", 32'(bus.wr_ack), 32'd1);
        @(negedge clk);
        bus.wr_req = 1'b0;
        @(posedge clk);
        #1;
        check("wr_ack_single", 32'(bus.wr_ack), 32'd0);
        if (col < 28 && row < 31) model[row * 28 + col] = {5'(tile), 2'(rot)};
    endtask

    // Release reset and count cycles until the sweep finishes
    task automatic release_and_count(input string name);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n), 32'd868);
        for (int i = 0; i < 868; i++) model[i] = 7'd0;
    endtask

    vec_t vecs [12];

    initial begin
        logic [13:0] r;
        int acks;

        vecs[0]  = '{x: 10'd235, y: 10'd137, v: 1'b1, exp: ex(5'd4, 2'd1, 3'd3, 3'd5, 1'b1)};
        vecs[1]  = '{x: 10'd100, y: 10'd137, v: 1'b1, exp: ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b0)};
        vecs[2]  = '{x: 10'd432, y: 10'd137, v: 1'b1, exp: ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b0)};
        vecs[3]  = '{x: 10'd208, y: 10'd116, v: 1'b1, exp: ex(5'd2, 2'd3, 3'd0, 3'd0, 1'b1)};
        vecs[4]  = '{x: 10'd431, y: 10'd363, v: 1'b1, exp: ex(5'd3, 2'd2, 3'd7, 3'd7, 1'b1)};
        vecs[5]  = '{x: 10'd431, y: 10'd364, v: 1'b1, exp: ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b0)};
        vecs[6]  = '{x: 10'd235, y: 10'd137, v: 1'b0, exp: ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b0)};
        vecs[7]  = '{x: 10'd208, y: 10'd115, v: 1'b1, exp: ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b0)};
        vecs[8]  = '{x: 10'd207, y: 10'd116, v: 1'b1, exp: ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b0)};
        vecs[9]  = '{x: 10'd216, y: 10'd116, v: 1'b1, exp: ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b1)};
        vecs[10] = '{x: 10'd239, y: 10'd131, v: 1'b1, exp: ex(5'd0, 2'd0, 3'd7, 3'd7, 1'b1)};
        vecs[11] = '{x: 10'd232, y: 10'd132, v: 1'b1, exp: ex(5'd4, 2'd1, 3'd0, 3'd0, 1'b1)};

        bus.pix_x = '0; bus.pix_y = '0; bus.pix_valid = 1'b0;
        bus.wr_req = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_tile = '0; bus.wr_rot = '0;

        // Reset state
        #12;
        check("reset_state", 32'({bus.wr_ack, bus.busy, outs()}), 32'({1'b0, 1'b1, 14'd0}));
        release_and_count("busy_cycles");
        check("idle_outputs", 32'({bus.wr_ack, bus.busy, outs()}), 32'd0);
        readback("clear_readback");

        // Spec example write and a few extra cells for the vector table
        write_tile(3, 2, 4, 1);
        write_tile(0, 0, 2, 3);
        write_tile(27, 30, 3, 2);

        // Streamed vectors: result of vector i appears after the edge following its capture
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i < 12) begin
                bus.pix_x = vecs[i].x;
                bus.pix_y = vecs[i].y;
                bus.pix_valid = vecs[i].v;
            end else begin
                bus.pix_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= 1) check($sformatf("vec%0d", i - 1), 32'(outs()), 32'(vecs[i - 1].exp));
        end

        // Held request: acks on alternate cycles only
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.wr_col = 5'd3; bus.wr_row = 5'd2; bus.wr_tile = 5'd4; bus.wr_rot = 2'd1;
        bus.wr_req = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.wr_ack) acks++;
        end
        check("alt_acks", 32'(acks), 32'd3);
        @(negedge clk);
        bus.wr_req = 1'b0;
        @(posedge clk);

        // Request stalled by active video for 50 cycles
        @(negedge clk);
        bus.pix_x = 10'd235; bus.pix_y = 10'd137; bus.pix_valid = 1'b1;
        bus.wr_col = 5'd10; bus.wr_row = 5'd10; bus.wr_tile = 5'd6; bus.wr_rot = 2'd2;
        bus.wr_req = 1'b1;
        acks = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.wr_ack) acks++;
        end
        check("stall_no_ack", 32'(acks), 32'd0);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stall_release_ack", 32'(bus.wr_ack), 32'd1);
        @(negedge clk);
        bus.wr_req = 1'b0;
        model[10 * 28 + 10] = {5'd6, 2'd2};
        probe(292, 202, r);
        check("stall_data", 32'(r), 32'(ex(5'd6, 2'd2, 3'd4, 3'd6, 1'b1)));

        // Out-of-range writes acknowledged, map untouched
        write_tile(28, 0, 5, 1);
        write_tile(0, 31, 5, 1);
        readback("oob_readback");

        // Reset in the middle of a sweep with a pending request
        write_tile(0, 0, 7, 0);
        probe(208, 116, r);
        check("cell0_written", 32'(r), 32'(ex(5'd7, 2'd0, 3'd0, 3'd0, 1'b1)));
        @(negedge clk);
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_col = 5'd5; bus.wr_row = 5'd0; bus.wr_tile = 5'd9; bus.wr_rot = 2'd1;
        bus.wr_req = 1'b1;
        acks = 0;
        repeat (400) begin
            @(posedge clk);
            #1;
            if (bus.wr_ack) acks++;
        end
        check("sweep_no_ack", 32'(acks), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midsweep_reset", 32'({bus.wr_ack, bus.busy, outs()}), 32'({1'b0, 1'b1, 14'd0}));
        bus.wr_req = 1'b0;
        release_and_count("busy_after_restart");
        probe(208, 116, r);
        check("cell0_cleared", 32'(r), 32'(ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b1)));
        probe(248, 116, r);
        check("cell5_clear", 32'(r), 32'(ex(5'd0, 2'd0, 3'd0, 3'd0, 1'b1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
